// File: rtl/tdm_frame_converter.sv
// Serial TDM frame converter: oversamples the STM bit clock in clk50, buffers one
// frame of received bits and returns delay/bypass/loopback/mute data with frame alignment.
module tdm_frame_converter #(
  parameter int CHANNELS   = 48,
  parameter int BITS       = 8,
  parameter int FRAME_BITS = CHANNELS * BITS,
  parameter int CW         = $clog2(FRAME_BITS)
) (
  input  logic          clk50,
  input  logic          reset_in_rg,
  input  logic          clk_from_stm,
  input  logic          f0,
  input  logic          data_from_stm,
  input  logic          data_from_dt,
  input  logic [1:0]    mode,
  input  logic          err_clr,
  output logic          data_to_stm,
  output logic          cpu_int,
  output logic          frame_err,
  output logic          locked,
  output logic [CW-1:0] bit_cnt
);

  localparam logic [CW-1:0] LAST   = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] PENULT = CW'(FRAME_BITS - 2);

  typedef enum logic [1:0] {UNLOCKED = 2'd0, SEEK = 2'd1, LOCKED = 2'd2} state_t;

  logic [2:0]            r_clk_s;
  logic [1:0]            r_f0_s, r_dstm_s, r_ddt_s;
  logic [FRAME_BITS-1:0] r_sr;
  logic                  r_int_pend;
  state_t                r_state, w_state_nxt;
  logic                  w_tick, w_f0, w_dstm, w_ddt, w_at_last;
  logic                  w_good, w_misplaced, w_missing, w_out_nxt;

  // Sync stages reset to 0 so a clock held high at release looks like a rising edge, not a tick
  always_ff @(posedge clk50 or negedge reset_in_rg) begin
    if (!reset_in_rg) begin
      r_clk_s  <= '0;
      r_f0_s   <= '0;
      r_dstm_s <= '0;
      r_ddt_s  <= '0;
    end else begin
      r_clk_s  <= {r_clk_s[1:0], clk_from_stm};
      r_f0_s   <= {r_f0_s[0], f0};
      r_dstm_s <= {r_dstm_s[0], data_from_stm};
      r_ddt_s  <= {r_ddt_s[0], data_from_dt};
    end
  end

  assign w_tick      = r_clk_s[2] & ~r_clk_s[1];
  assign w_f0        = r_f0_s[1];
  assign w_dstm      = r_dstm_s[1];
  assign w_ddt       = r_ddt_s[1];
  assign w_at_last   = (bit_cnt == LAST);
  assign w_good      = w_tick & ~w_f0 & w_at_last;
  assign w_misplaced = w_tick & ~w_f0 & ~w_at_last;
  assign w_missing   = w_tick & w_f0 & w_at_last;

  always_ff @(posedge clk50 or negedge reset_in_rg) begin
    if (!reset_in_rg) r_state <= UNLOCKED;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_misplaced || w_missing) begin
      w_state_nxt = UNLOCKED;
    end else if (w_good) begin
      case (r_state)
        UNLOCKED: w_state_nxt = SEEK;
        SEEK:     w_state_nxt = LOCKED;
        LOCKED:   w_state_nxt = LOCKED;
        default:  w_state_nxt = UNLOCKED;
      endcase
    end
  end

  always_comb begin
    locked = (r_state == LOCKED);
  end

  always_comb begin
    w_out_nxt = 1'b1;
    case (mode)
      2'b00:   w_out_nxt = r_sr[FRAME_BITS-1];
      2'b01:   w_out_nxt = w_dstm;
      2'b10:   w_out_nxt = w_ddt;
      default: w_out_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk50 or negedge reset_in_rg) begin
    if (!reset_in_rg) begin
      r_sr        <= '0;
      data_to_stm <= 1'b0;
      bit_cnt     <= '0;
    end else if (w_tick) begin
      r_sr        <= {r_sr[FRAME_BITS-2:0], w_dstm};
      data_to_stm <= w_out_nxt;
      bit_cnt     <= (!w_f0 || w_at_last) ? '0 : bit_cnt + CW'(1);
    end
  end

  // A sync fault while locked outranks a simultaneous clear
  always_ff @(posedge clk50 or negedge reset_in_rg) begin
    if (!reset_in_rg)                                 frame_err <= 1'b0;
    else if ((w_misplaced || w_missing) && locked)    frame_err <= 1'b1;
    else if (err_clr)                                 frame_err <= 1'b0;
  end

  // Interrupt trails the bit_cnt load of the last frame bit by one cycle
  always_ff @(posedge clk50 or negedge reset_in_rg) begin
    if (!reset_in_rg) begin
      r_int_pend <= 1'b0;
      cpu_int    <= 1'b0;
    end else begin
      r_int_pend <= w_tick & w_f0 & (bit_cnt == PENULT) & locked;
      cpu_int    <= r_int_pend;
    end
  end

endmodule
